// File: rtl/mld_15_7_pkg.sv
// Shared constants and state encoding for the (15,7) majority-logic decoder controller.
package mld_15_7_pkg;

    localparam int N     = 15;
    localparam int K     = 7;
    localparam int T     = 2;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DECODE,
        DONE
    } state_t;

endpackage

// File: rtl/mld_15_7_controller_piso_15.sv
// 15-bit parallel-load, shift-left register; MSB feeds the decoder serial input.
module piso_15
    import mld_15_7_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] din,
    output logic         msb
);

    logic [N-1:0] sr_q;

    // Parallel load has priority over shifting; zeros fill from the LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= {sr_q[N-2:0], 1'b0};
        end
    end

    assign msb = sr_q[N-1];

endmodule

// File: rtl/mld_15_7_controller.sv
// Sequencing controller: accepts a codeword, streams it through the serial
// decoder, collects the corrected stream and presents the result.
module mld_15_7_controller
    import mld_15_7_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         cw_valid,
    output logic         cw_ready,
    input  logic [N-1:0] cw_data,
    input  logic         bypass,
    output logic         dec_reset,
    output logic         dec_load,
    output logic         dec_bit,
    output logic         dec_correct_errors,
    input  logic         dec_out_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_codeword,
    output logic [K-1:0] out_message,
    output logic [3:0]   out_ncorr,
    output logic         busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     raw_q;
    logic             bypass_q;
    logic             out_valid_q;
    logic             dec_load_q;
    logic             dec_ce_q;
    logic [N-1:0]     codeword_q;
    logic [3:0]       ncorr_q;
    logic             accept;
    logic             piso_msb;
    logic [CNT_W-1:0] bit_idx;

    assign accept  = (state_q == IDLE) && cw_valid;
    // Position of the bit currently leaving the decoder (MSB first).
    assign bit_idx = LAST - cnt_q;

    piso_15 u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (state_q == LOAD),
        .din   (cw_data),
        .msb   (piso_msb)
    );

    // Main FSM with counter, deserializer, correction counter and registered controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            raw_q       <= '0;
            bypass_q    <= 1'b0;
            out_valid_q <= 1'b0;
            dec_load_q  <= 1'b0;
            dec_ce_q    <= 1'b1;
            codeword_q  <= '0;
            ncorr_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cw_valid) begin
                        raw_q    <= cw_data;
                        bypass_q <= bypass;
                        ncorr_q  <= '0;
                        state_q  <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt_q      <= '0;
                    dec_load_q <= 1'b1;
                    state_q    <= LOAD;
                end
                LOAD: begin
                    if (cnt_q == LAST) begin
                        cnt_q      <= '0;
                        dec_load_q <= 1'b0;
                        // Low enables correction in the decoder.
                        dec_ce_q   <= bypass_q;
                        state_q    <= DECODE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DECODE: begin
                    codeword_q[bit_idx] <= dec_out_bit;
                    if ((dec_out_bit != raw_q[bit_idx]) && (ncorr_q != 4'hF)) begin
                        ncorr_q <= ncorr_q + 4'd1;
                    end
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        dec_ce_q    <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decodes of registered state; the decoder is held clear throughout reset.
    always_comb begin
        cw_ready           = (state_q == IDLE);
        busy               = (state_q != IDLE);
        dec_reset          = ~reset | (state_q == CLEAR);
        dec_load           = dec_load_q;
        dec_bit            = (state_q == LOAD) & piso_msb;
        dec_correct_errors = dec_ce_q;
        out_valid          = out_valid_q;
        out_codeword       = codeword_q;
        out_message        = codeword_q[N-1:N-K];
        out_ncorr          = ncorr_q;
    end

endmodule

// File: tb/tb_mld_15_7_controller.sv
// Self-checking bench: behavioural serial decoder plus nearest-codeword reference.
module tb_mld_15_7_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cw_valid;
    logic        cw_ready;
    logic [14:0] cw_data;
    logic        bypass;
    logic        dec_reset;
    logic        dec_load;
    logic        dec_bit;
    logic        dec_correct_errors;
    logic        dec_out_bit;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_codeword;
    logic [6:0]  out_message;
    logic [3:0]  out_ncorr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit inv_dec = 1'b0;

    always #5 clk = ~clk;

    mld_15_7_controller dut (
        .clk                (clk),
        .reset              (reset),
        .cw_valid           (cw_valid),
        .cw_ready           (cw_ready),
        .cw_data            (cw_data),
        .bypass             (bypass),
        .dec_reset          (dec_reset),
        .dec_load           (dec_load),
        .dec_bit            (dec_bit),
        .dec_correct_errors (dec_correct_errors),
        .dec_out_bit        (dec_out_bit),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_codeword       (out_codeword),
        .out_message        (out_message),
        .out_ncorr          (out_ncorr),
        .busy               (busy)
    );

    // Systematic (15,7) cyclic code, g(x) = x^8 + x^7 + x^6 + x^4 + 1.
    function automatic logic [14:0] encode(input logic [6:0] msg);
        logic [14:0] r;
        r = {msg, 8'h00};
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (15'(9'h1D1) << (i - 8));
        end
        return {msg, r[7:0]};
    endfunction

    function automatic int popcnt(input logic [14:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 15; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [14:0] nearest(input logic [14:0] w);
        logic [14:0] best;
        int          bd;
        best = '0;
        bd   = 99;
        for (int m = 0; m < 128; m++) begin
            if (popcnt(encode(7'(m)) ^ w) < bd) begin
                bd   = popcnt(encode(7'(m)) ^ w);
                best = encode(7'(m));
            end
        end
        return best;
    endfunction

    // Behavioural serial decoder: shifts in loaded bits, then emits the word MSB first.
    logic [14:0] m_word;
    int          m_nout;

    always @(posedge clk) begin
        if (dec_reset) begin
            m_word <= '0;
            m_nout <= 0;
        end else if (dec_load) begin
            m_word <= {m_word[13:0], dec_bit};
            m_nout <= 0;
        end else if (m_nout < 15) begin
            m_nout <= m_nout + 1;
        end
    end

    always_comb begin
        logic [14:0] v;
        v = dec_correct_errors ? m_word : nearest(m_word);
        if (inv_dec) v = ~v;
        dec_out_bit = (m_nout < 15) ? v[14 - m_nout] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic do_word(input logic [14:0] cw, input bit byp, input int hold);
        logic [14:0] exp_cw;
        logic [14:0] loaded;
        int          cyc;
        int          nload;
        int          nce0;
        int          nc;
        exp_cw = byp ? cw : nearest(cw);
        if (inv_dec) exp_cw = ~exp_cw;
        nc = popcnt(exp_cw ^ cw);
        if (nc > 15) nc = 15;
        out_ready = (hold == 0);
        check("cw_ready_idle", 32'(cw_ready), 32'd1);
        cw_valid = 1'b1;
        cw_data  = cw;
        bypass   = byp;
        @(negedge clk);
        cw_valid = 1'b0;
        bypass   = $urandom_range(0, 1);
        check("clear_dec_reset", 32'(dec_reset), 32'd1);
        check("clear_dec_load", 32'(dec_load), 32'd0);
        cyc    = 1;
        nload  = 0;
        nce0   = 0;
        loaded = '0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dec_load) begin
                loaded = {loaded[13:0], dec_bit};
                nload++;
            end
            if (!dec_correct_errors) nce0++;
        end
        check("out_valid_cycle", 32'(cyc), 32'd32);
        check("loaded_stream", 32'(loaded), 32'(cw));
        check("load_cycles", 32'(nload), 32'd15);
        check("correct_cycles", 32'(nce0), byp ? 32'd0 : 32'd15);
        check("codeword", 32'(out_codeword), 32'(exp_cw));
        check("message", 32'(out_message), 32'(exp_cw[14:8]));
        check("ncorr", 32'(out_ncorr), 32'(nc));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_codeword", 32'(out_codeword), 32'(exp_cw));
            check("hold_ncorr", 32'(out_ncorr), 32'(nc));
            check("hold_cw_ready", 32'(cw_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_after_done", 32'(out_valid), 32'd0);
        check("idle_cw_ready", 32'(cw_ready), 32'd1);
    endtask

    initial begin
        logic [14:0] w;
        int          p1;
        int          p2;
        int          ne;
        reset     = 1'b0;
        cw_valid  = 1'b0;
        cw_data   = '0;
        bypass    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_codeword", 32'(out_codeword), 32'd0);
        check("rst_ncorr", 32'(out_ncorr), 32'd0);
        check("rst_dec_load", 32'(dec_load), 32'd0);
        check("rst_dec_bit", 32'(dec_bit), 32'd0);
        check("rst_dec_ce", 32'(dec_correct_errors), 32'd1);
        check("rst_dec_reset", 32'(dec_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        check("rel_cw_ready", 32'(cw_ready), 32'd1);

        do_word(15'h0000, 1'b0, 0);
        do_word(15'h0001, 1'b0, 0);
        do_word(15'h4001, 1'b0, 0);
        do_word(15'h0001, 1'b1, 0);
        do_word(encode(7'h55) ^ 15'h0100, 1'b0, 10);
        do_word(encode(7'h2A) ^ 15'h2004, 1'b0, 0);

        // Abort mid-LOAD with an asynchronous reset.
        cw_valid = 1'b1;
        cw_data  = 15'h4001;
        @(negedge clk);
        cw_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_abort_load", 32'(dec_load), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_dec_reset", 32'(dec_reset), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_cw_ready", 32'(cw_ready), 32'd1);
        check("abort_dec_load", 32'(dec_load), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_word(15'h0001, 1'b0, 0);

        // Decoder flipping every bit exercises the full 15-position count.
        inv_dec = 1'b1;
        do_word(15'h0000, 1'b0, 0);
        inv_dec = 1'b0;

        for (int n = 0; n < 20; n++) begin
            w  = encode(7'($urandom_range(0, 127)));
            ne = $urandom_range(0, 2);
            p1 = $urandom_range(0, 14);
            p2 = (p1 + $urandom_range(1, 14)) % 15;
            if (ne >= 1) w[p1] = ~w[p1];
            if (ne == 2) w[p2] = ~w[p2];
            do_word(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
